// File: rtl/seg7_nibble_sequencer_pkg.sv
// Shared types and sizing helpers for the 7-segment nibble sequencer.
package seg7_nibble_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } seq_state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // A counter always needs at least one bit, even when both periods are 1.
  function automatic int unsigned timer_width(input int unsigned dwell,
                                              input int unsigned gap);
    int unsigned m;
    int unsigned w;
    m = (dwell > gap) ? dwell : gap;
    w = clog2(m);
    return (w == 0) ? 1 : w;
  endfunction

  localparam int unsigned DWELL_DEFAULT = 1000;
  localparam int unsigned GAP_DEFAULT   = 250;
  localparam int unsigned TIMER_W       = timer_width(DWELL_DEFAULT, GAP_DEFAULT);

endpackage

// File: rtl/seg7_dwell_timer.sv
// Loadable down-counter that stops at zero and flags it.
module seg7_dwell_timer #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/seg7_nibble_sequencer.sv
// Presents a multi-nibble word one hex digit at a time, MSB first,
// each digit followed by a blanked gap.
module seg7_nibble_sequencer
  import seg7_nibble_sequencer_pkg::*;
#(
  parameter int unsigned NIBBLES      = 4,
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned GAP_CYCLES   = 250
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4*NIBBLES-1:0]   in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   repeat_en,
  output logic [3:0]             nibble,
  output logic                   blank,
  output logic                   dp,
  output logic                   busy
);

  localparam int unsigned TW = timer_width(DWELL_CYCLES, GAP_CYCLES);
  localparam int unsigned IW = (clog2(NIBBLES) == 0) ? 1 : clog2(NIBBLES);

  localparam logic [TW-1:0] DWELL_LD = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_TOP  = IW'(NIBBLES - 1);

  seq_state_t                  state, state_n;
  logic [NIBBLES-1:0][3:0]     word, word_n;
  logic [IW-1:0]               idx, idx_n;
  logic                        t_load;
  logic [TW-1:0]               t_value;
  logic                        t_zero;
  logic                        accept;

  seg7_dwell_timer #(
    .W (TW)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (t_load),
    .load_value (t_value),
    .enable     (state != IDLE),
    .zero       (t_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      word  <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      word  <= word_n;
      idx   <= idx_n;
    end
  end

  assign in_ready = (state == IDLE) || ((state == GAP) && (idx == '0));
  assign accept   = in_valid && in_ready;

  // An accept wins over any timer expiry, which is what cuts the final gap short.
  always_comb begin
    state_n = state;
    word_n  = word;
    idx_n   = idx;
    t_load  = 1'b0;
    t_value = '0;
    if (accept) begin
      word_n  = in_data;
      idx_n   = IDX_TOP;
      t_load  = 1'b1;
      t_value = DWELL_LD;
      state_n = SHOW;
    end else begin
      case (state)
        SHOW: begin
          if (t_zero) begin
            state_n = GAP;
            t_load  = 1'b1;
            t_value = GAP_LD;
          end
        end
        GAP: begin
          if (t_zero) begin
            if (idx != '0) begin
              idx_n   = idx - 1'b1;
              state_n = SHOW;
              t_load  = 1'b1;
              t_value = DWELL_LD;
            end else if (repeat_en) begin
              idx_n   = IDX_TOP;
              state_n = SHOW;
              t_load  = 1'b1;
              t_value = DWELL_LD;
            end else begin
              state_n = IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nibble = '0;
    blank  = 1'b1;
    dp     = 1'b0;
    busy   = (state != IDLE);
    if (state == SHOW) begin
      nibble = word[idx];
      blank  = 1'b0;
      dp     = (idx == IDX_TOP);
    end
  end

endmodule

// File: tb/tb_seg7_nibble_sequencer.sv
// Directed bench for seg7_nibble_sequencer with NIBBLES=4, DWELL=3, GAP=2.
module tb_seg7_nibble_sequencer;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        repeat_en;
  logic [3:0]  nibble;
  logic        blank;
  logic        dp;
  logic        busy;

  int unsigned n_cmp;
  int unsigned n_bad;

  localparam logic [7:0] IDLE_OUT = 8'h09;

  seg7_nibble_sequencer #(
    .NIBBLES      (4),
    .DWELL_CYCLES (3),
    .GAP_CYCLES   (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .repeat_en (repeat_en),
    .nibble    (nibble),
    .blank     (blank),
    .dp        (dp),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Observation vector: {nibble, blank, dp, busy, in_ready}
  function automatic logic [7:0] obs();
    return {nibble, blank, dp, busy, in_ready};
  endfunction

  // Expected observation in frame cycle c (1..20) of word w: 3 shown, 2 blank per digit.
  function automatic logic [7:0] frame_exp(input logic [15:0] w, input int c);
    int digit;
    int pos;
    logic [15:0] sh;
    digit = (c - 1) / 5;
    pos   = (c - 1) % 5;
    sh    = w >> (4 * (3 - digit));
    if (pos < 3) return {sh[3:0], 1'b0, (digit == 0), 1'b1, 1'b0};
    else         return {4'h0, 1'b1, 1'b0, 1'b1, (digit == 3)};
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [15:0] w);
    in_valid = 1'b1;
    in_data  = w;
    step();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    repeat_en = 1'b0;
    step();
    step();
    check("reset", obs(), IDLE_OUT);
    rst_n = 1'b1;
    step();
    check("idle", obs(), IDLE_OUT);

    // Single frame, no repeat
    accept(16'hA5C3);
    for (int c = 1; c <= 20; c++) begin
      check($sformatf("t1_c%0d", c), obs(), frame_exp(16'hA5C3, c));
      step();
    end
    check("t1_c21_idle", obs(), IDLE_OUT);

    // Repeat loops the word
    repeat_en = 1'b1;
    accept(16'hA5C3);
    for (int c = 1; c <= 23; c++) begin
      check($sformatf("t2_c%0d", c), obs(), frame_exp(16'hA5C3, (c > 20) ? c - 20 : c));
      step();
    end
    repeat_en = 1'b0;
    do_reset();
    check("t2_post_reset", obs(), IDLE_OUT);

    // New word during the final gap preempts the repeat
    repeat_en = 1'b1;
    accept(16'hA5C3);
    for (int c = 1; c <= 19; c++) begin
      check($sformatf("t3_c%0d", c), obs(), frame_exp(16'hA5C3, c));
      if (c < 19) step();
    end
    accept(16'h1234);
    for (int c = 20; c <= 24; c++) begin
      check($sformatf("t3_new_c%0d", c), obs(), frame_exp(16'h1234, c - 19));
      step();
    end
    repeat_en = 1'b0;
    do_reset();

    // Offers while not ready are ignored
    accept(16'hA5C3);
    for (int c = 1; c <= 20; c++) begin
      check($sformatf("t4_c%0d", c), obs(), frame_exp(16'hA5C3, c));
      in_valid = (c >= 2 && c <= 18);
      in_data  = (c >= 2 && c <= 18) ? 16'hFFFF : 16'h0000;
      step();
    end
    in_valid = 1'b0;
    check("t4_c21_idle", obs(), IDLE_OUT);

    // Reset mid-SHOW discards the word; next word starts at its MSB
    accept(16'hA5C3);
    for (int c = 1; c <= 7; c++) begin
      check($sformatf("t5_c%0d", c), obs(), frame_exp(16'hA5C3, c));
      if (c < 7) step();
    end
    rst_n = 1'b0;
    step();
    check("t5_c8_reset", obs(), IDLE_OUT);
    rst_n = 1'b1;
    accept(16'h9E70);
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("t5_new_c%0d", c), obs(), frame_exp(16'h9E70, c));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
